// File: rtl/usb_pkg.sv
// Shared PID codes, sequencer state encoding and DATA-PID helper for the
// USB endpoint sequencer.
package usb_pkg;

   localparam logic [3:0] PID_IDLE  = 4'b0000;
   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX_DATA,
      S_RX_END,
      S_TX_REQ,
      S_TX_BUSY,
      S_WAIT_ACK
   } seq_state_t;

   // What happens once the TX engine has finished the requested packet
   typedef enum logic [1:0] {
      POST_IDLE,
      POST_DONE,
      POST_WAIT_ACK
   } post_t;

   function automatic logic [3:0] data_pid(input logic toggle);
      return toggle ? PID_DATA1 : PID_DATA0;
   endfunction

endpackage

// File: rtl/usb_seq_timer.sv
// 8-bit clearable timeout counter: counts while run is high, restarts from 0
// whenever run drops, and pulses expire for one cycle at TIMEOUT_CYCLES-1.
module usb_seq_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 128
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic expire
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] count;

   // Parks one past LIMIT so expire cannot repeat and the count never wraps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (!run) begin
         count <= '0;
      end else if (count != LIMIT + 8'd1) begin
         count <= count + 8'd1;
      end
   end

   assign expire = run && (count == LIMIT);

endmodule

// File: rtl/usb_ep_sequencer.sv
// Device-side bulk endpoint transaction sequencer (OUT/DATA/handshake and
// IN/DATA/ACK). Define USB_EP_SEQ_STALL_EN to honour ep_halt with STALL.
module usb_ep_sequencer
   import usb_pkg::*;
#(
   parameter int unsigned BUF_DEPTH      = 64,
   parameter int unsigned TIMEOUT_CYCLES = 128
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_pid_valid,
   input  logic [3:0] rx_packet,
   input  logic       rx_transfer_active,
   input  logic       rx_error,
   input  logic [6:0] buffer_occupancy,
   input  logic       tx_transfer_active,
   input  logic       tx_error,
   input  logic       ep_halt,
   output logic [3:0] tx_packet,
   output logic       d_mode,
   output logic       clear,
   output logic       txn_done,
   output logic       txn_error,
   output logic       tx_toggle,
   output logic       rx_toggle
);

`ifdef USB_EP_SEQ_STALL_EN
   localparam logic STALL_EN = 1'b1;
`else
   localparam logic STALL_EN = 1'b0;
`endif

   seq_state_t state, state_d;
   post_t      post_q, post_d;
   logic [3:0] pend_q, pend_d;
   logic       dtog_q, dtog_d;
   logic       tx_tog_d, rx_tog_d;
   logic       clear_d, done_d, err_d;
   logic       halt, buf_empty, buf_full;
   logic       timer_run, expire;

   assign halt      = ep_halt & STALL_EN;
   assign buf_empty = (buffer_occupancy == '0);
   assign buf_full  = (buffer_occupancy == 7'(BUF_DEPTH));
   assign timer_run = (state == S_RX_DATA) || (state == S_WAIT_ACK) || (state == S_TX_REQ);

   usb_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .run    (timer_run),
      .expire (expire)
   );

   always_comb begin
      state_d  = state;
      post_d   = post_q;
      pend_d   = pend_q;
      dtog_d   = dtog_q;
      tx_tog_d = tx_toggle;
      rx_tog_d = rx_toggle;
      clear_d  = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (rx_pid_valid && rx_packet == PID_OUT) begin
               state_d = S_RX_DATA;
            end else if (rx_pid_valid && rx_packet == PID_IN) begin
               state_d = S_TX_REQ;
               post_d  = POST_IDLE;
               if (halt) begin
                  pend_d = PID_STALL;
               end else if (buf_empty) begin
                  pend_d = PID_NAK;
               end else begin
                  pend_d = data_pid(tx_toggle);
                  post_d = POST_WAIT_ACK;
               end
            end
         end
         S_RX_DATA: begin
            if (rx_pid_valid && (rx_packet == PID_DATA0 || rx_packet == PID_DATA1)) begin
               dtog_d  = rx_packet[3];
               state_d = S_RX_END;
            end else if (rx_pid_valid || expire) begin
               err_d   = 1'b1;
               clear_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_RX_END: begin
            if (!rx_transfer_active) begin
               state_d = S_TX_REQ;
               post_d  = POST_IDLE;
               pend_d  = PID_ACK;
               if (rx_error) begin
                  err_d   = 1'b1;
                  clear_d = 1'b1;
                  state_d = S_IDLE;
               end else if (halt) begin
                  pend_d = PID_STALL;
               end else if (buf_full) begin
                  pend_d  = PID_NAK;
                  clear_d = 1'b1;
               end else if (dtog_q != rx_toggle) begin
                  clear_d = 1'b1;
               end else begin
                  rx_tog_d = ~rx_toggle;
                  post_d   = POST_DONE;
               end
            end
         end
         S_TX_REQ: begin
            if (tx_error) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (tx_transfer_active) begin
               state_d = S_TX_BUSY;
            end else if (expire) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_TX_BUSY: begin
            if (tx_error) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (!tx_transfer_active) begin
               state_d = (post_q == POST_WAIT_ACK) ? S_WAIT_ACK : S_IDLE;
               done_d  = (post_q == POST_DONE);
            end
         end
         S_WAIT_ACK: begin
            if (rx_pid_valid && rx_packet == PID_ACK) begin
               tx_tog_d = ~tx_toggle;
               clear_d  = 1'b1;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end else if (rx_pid_valid || rx_error || expire) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         post_q    <= POST_IDLE;
         pend_q    <= PID_IDLE;
         dtog_q    <= 1'b0;
         tx_packet <= PID_IDLE;
         d_mode    <= 1'b0;
         clear     <= 1'b0;
         txn_done  <= 1'b0;
         txn_error <= 1'b0;
         tx_toggle <= 1'b0;
         rx_toggle <= 1'b0;
      end else begin
         state     <= state_d;
         post_q    <= post_d;
         pend_q    <= pend_d;
         dtog_q    <= dtog_d;
         tx_packet <= (state_d == S_TX_REQ) ? pend_d : PID_IDLE;
         d_mode    <= (state_d == S_TX_REQ) || (state_d == S_TX_BUSY);
         clear     <= clear_d;
         txn_done  <= done_d;
         txn_error <= err_d;
         tx_toggle <= tx_tog_d;
         rx_toggle <= rx_tog_d;
      end
   end

endmodule

// File: tb/tb_usb_ep_sequencer.sv
// Scoreboard bench for usb_ep_sequencer: expected TX PIDs and status pulses
// are queued as host stimulus is driven and popped as the DUT produces them.
module tb_usb_ep_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_pid_valid;
   logic [3:0] rx_packet;
   logic       rx_transfer_active;
   logic       rx_error;
   logic [6:0] buffer_occupancy;
   logic       tx_transfer_active;
   logic       tx_error;
   logic       ep_halt;
   logic [3:0] tx_packet;
   logic       d_mode, clear, txn_done, txn_error, tx_toggle, rx_toggle;

   int checks = 0;
   int failures = 0;
   int clear_cnt = 0;
   logic inject_tx_err = 1'b0;
   logic clear_prev = 1'b0;

   logic [3:0] exp_pkt[$];
   logic [1:0] exp_stat[$];   // {done, error}

   localparam logic [1:0] ST_DONE = 2'b10;
   localparam logic [1:0] ST_ERR  = 2'b01;

   usb_ep_sequencer #(.BUF_DEPTH(64), .TIMEOUT_CYCLES(128)) dut (
      .clk                (clk),
      .rst                (rst),
      .rx_pid_valid       (rx_pid_valid),
      .rx_packet          (rx_packet),
      .rx_transfer_active (rx_transfer_active),
      .rx_error           (rx_error),
      .buffer_occupancy   (buffer_occupancy),
      .tx_transfer_active (tx_transfer_active),
      .tx_error           (tx_error),
      .ep_halt            (ep_halt),
      .tx_packet          (tx_packet),
      .d_mode             (d_mode),
      .clear              (clear),
      .txn_done           (txn_done),
      .txn_error          (txn_error),
      .tx_toggle          (tx_toggle),
      .rx_toggle          (rx_toggle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // TX engine model: accepts a requested PID, sends it, optionally errors
   initial begin
      tx_transfer_active = 1'b0;
      tx_error = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && tx_packet != 4'h0 && !tx_transfer_active) begin
            if (exp_pkt.size() == 0) check("unexpected_tx_pkt", 8'(tx_packet), 8'h0);
            else check("tx_pkt", 8'(tx_packet), 8'(exp_pkt.pop_front()));
            @(negedge clk);
            tx_transfer_active = 1'b1;
            repeat (3) @(negedge clk);
            if (inject_tx_err) begin
               tx_error = 1'b1;
               @(negedge clk);
               tx_error = 1'b0;
            end
            tx_transfer_active = 1'b0;
         end
      end
   end

   // Status / pulse monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (txn_done || txn_error) begin
            check("status_exclusive", 8'(txn_done & txn_error), 8'h0);
            if (exp_stat.size() == 0) check("unexpected_status", 8'({txn_done, txn_error}), 8'h0);
            else check("status", 8'({txn_done, txn_error}), 8'(exp_stat.pop_front()));
         end
         if (clear) begin
            clear_cnt++;
            check("clear_width", 8'(clear_prev), 8'h0);
         end
         clear_prev = clear;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send_pid(input logic [3:0] pid);
      rx_error = 1'b0;
      rx_packet = pid;
      rx_pid_valid = 1'b1;
      @(negedge clk);
      rx_pid_valid = 1'b0;
   endtask

   task automatic send_data(input logic [3:0] pid, input logic err);
      rx_error = 1'b0;
      rx_packet = pid;
      rx_pid_valid = 1'b1;
      rx_transfer_active = 1'b1;
      @(negedge clk);
      rx_pid_valid = 1'b0;
      repeat (2) @(negedge clk);
      rx_error = err;
      rx_transfer_active = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_in();
      send_pid(4'b1001);
      check("in_latency", 8'(tx_packet != 4'h0), 8'h1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_pkt.size() != 0 || exp_stat.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check("drain_timeout", 8'h1, 8'h0);
      repeat (10) @(negedge clk);
   endtask

   task automatic wait_tx_done();
      int n = 0;
      while ((d_mode || exp_pkt.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("tx_done_timeout", 8'h1, 8'h0);
   endtask

   initial begin
      int c0;
      int cycles;
      rst = 1'b1;
      rx_pid_valid = 1'b0;
      rx_packet = 4'h0;
      rx_transfer_active = 1'b0;
      rx_error = 1'b0;
      buffer_occupancy = 7'd0;
      ep_halt = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_packet", 8'(tx_packet), 8'h0);
      check("rst_d_mode", 8'(d_mode), 8'h0);
      check("rst_clear", 8'(clear), 8'h0);
      check("rst_done", 8'(txn_done), 8'h0);
      check("rst_error", 8'(txn_error), 8'h0);
      check("rst_tx_toggle", 8'(tx_toggle), 8'h0);
      check("rst_rx_toggle", 8'(rx_toggle), 8'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // OUT + DATA1 while expecting DATA0: duplicate, ACK and flush only
      buffer_occupancy = 7'd10;
      c0 = clear_cnt;
      exp_pkt.push_back(4'b0010);
      send_pid(4'b0001);
      send_data(4'b1011, 1'b0);
      wait_drain();
      check("dup_rx_toggle", 8'(rx_toggle), 8'h0);
      check("dup_clear", 8'(clear_cnt - c0), 8'h1);

      // OUT + DATA0 fresh: ACK, toggle flips, done
      c0 = clear_cnt;
      exp_pkt.push_back(4'b0010);
      exp_stat.push_back(ST_DONE);
      send_pid(4'b0001);
      send_data(4'b0011, 1'b0);
      wait_drain();
      check("out_rx_toggle", 8'(rx_toggle), 8'h1);
      check("out_clear", 8'(clear_cnt - c0), 8'h0);

      // OUT + DATA1 with rx_error: no handshake, error and flush
      c0 = clear_cnt;
      exp_stat.push_back(ST_ERR);
      send_pid(4'b0001);
      send_data(4'b1011, 1'b1);
      wait_drain();
      check("rxerr_rx_toggle", 8'(rx_toggle), 8'h1);
      check("rxerr_clear", 8'(clear_cnt - c0), 8'h1);

      // OUT + DATA1 with buffer full: NAK and flush
      buffer_occupancy = 7'd64;
      c0 = clear_cnt;
      exp_pkt.push_back(4'b1010);
      send_pid(4'b0001);
      send_data(4'b1011, 1'b0);
      wait_drain();
      check("full_rx_toggle", 8'(rx_toggle), 8'h1);
      check("full_clear", 8'(clear_cnt - c0), 8'h1);

      // OUT then unexpected token
      c0 = clear_cnt;
      exp_stat.push_back(ST_ERR);
      send_pid(4'b0001);
      send_pid(4'b1001);
      wait_drain();
      check("badpid_clear", 8'(clear_cnt - c0), 8'h1);

      // OUT with no DATA: timeout
      c0 = clear_cnt;
      exp_stat.push_back(ST_ERR);
      send_pid(4'b0001);
      wait_drain();
      check("out_to_clear", 8'(clear_cnt - c0), 8'h1);

      // IN with empty buffer: NAK, no status
      buffer_occupancy = 7'd0;
      exp_pkt.push_back(4'b1010);
      send_in();
      wait_drain();

      // IN with data, host never ACKs: error after 128 cycles in WAIT_ACK
      buffer_occupancy = 7'd4;
      c0 = clear_cnt;
      exp_pkt.push_back(4'b0011);
      exp_stat.push_back(ST_ERR);
      send_in();
      wait_tx_done();
      cycles = 0;
      while (!txn_error && cycles < 300) begin
         @(negedge clk);
         cycles++;
      end
      check("ack_timeout_cycles", 8'(cycles), 8'd128);
      wait_drain();
      check("to_tx_toggle", 8'(tx_toggle), 8'h0);
      check("to_clear", 8'(clear_cnt - c0), 8'h0);

      // Retry IN, host ACKs
      c0 = clear_cnt;
      exp_pkt.push_back(4'b0011);
      send_in();
      wait_tx_done();
      exp_stat.push_back(ST_DONE);
      send_pid(4'b0010);
      wait_drain();
      check("in_tx_toggle", 8'(tx_toggle), 8'h1);
      check("in_clear", 8'(clear_cnt - c0), 8'h1);

      // Halted endpoint IN
      ep_halt = 1'b1;
`ifdef USB_EP_SEQ_STALL_EN
      exp_pkt.push_back(4'b1110);
      send_in();
      wait_drain();
      check("halt_tx_toggle", 8'(tx_toggle), 8'h1);
`else
      exp_pkt.push_back(4'b1011);
      send_in();
      wait_tx_done();
      exp_stat.push_back(ST_DONE);
      send_pid(4'b0010);
      wait_drain();
      check("halt_tx_toggle", 8'(tx_toggle), 8'h0);
`endif
      ep_halt = 1'b0;

      // TX engine error during DATA: error, toggle kept
      c0 = 32'(tx_toggle);
      inject_tx_err = 1'b1;
      exp_pkt.push_back(tx_toggle ? 4'b1011 : 4'b0011);
      exp_stat.push_back(ST_ERR);
      send_in();
      wait_drain();
      inject_tx_err = 1'b0;
      check("txerr_tx_toggle", 8'(tx_toggle), 8'(c0));

      // Reset while waiting for ACK: immediate return to reset values
      c0 = clear_cnt;
      exp_pkt.push_back(tx_toggle ? 4'b1011 : 4'b0011);
      send_in();
      wait_tx_done();
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_tx_packet", 8'(tx_packet), 8'h0);
      check("mid_rst_d_mode", 8'(d_mode), 8'h0);
      check("mid_rst_tx_toggle", 8'(tx_toggle), 8'h0);
      check("mid_rst_rx_toggle", 8'(rx_toggle), 8'h0);
      check("mid_rst_status", 8'({txn_done, txn_error}), 8'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_rst_clear", 8'(clear_cnt - c0), 8'h0);
      check("leftover_expect", 8'(exp_pkt.size() + exp_stat.size()), 8'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
